// File: rtl/axi_bridge_pkg.sv
// State encoding and AXI response codes shared by the Avalon <-> AXI4-Lite bridges.
package axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_XFER = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Avalon has no exclusive-access notion, so EXOKAY folds into OKAY.
    function automatic logic [1:0] map_axi_resp(input logic [1:0] axi_resp);
        return (axi_resp == RESP_EXOKAY) ? RESP_OKAY : axi_resp;
    endfunction

endpackage

// File: rtl/avalon_axi_lite_master_bridge_if.sv
// Avalon-MM slave side plus AXI4-Lite master side of the bridge, bundled as one bus.
interface avalon_axi_lite_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [31:0]         iAvsAddress;
    logic [DATA_W/8-1:0] iAvsByteenable;
    logic                iAvsRead;
    logic                iAvsWrite;
    logic [DATA_W-1:0]   iAvsWritedata;
    logic [DATA_W-1:0]   oAvsReaddata;
    logic [1:0]          oAvsResponse;
    logic                oAvsWaitrequest;

    logic [ADDR_W-1:0]   M_AXI_AWADDR;
    logic [2:0]          M_AXI_AWPROT;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY;
    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY;
    logic [1:0]          M_AXI_BRESP;
    logic                M_AXI_BVALID;
    logic                M_AXI_BREADY;
    logic [ADDR_W-1:0]   M_AXI_ARADDR;
    logic [2:0]          M_AXI_ARPROT;
    logic                M_AXI_ARVALID;
    logic                M_AXI_ARREADY;
    logic [DATA_W-1:0]   M_AXI_RDATA;
    logic [1:0]          M_AXI_RRESP;
    logic                M_AXI_RVALID;
    logic                M_AXI_RREADY;

    modport master (
        input  iAvsAddress, iAvsByteenable, iAvsRead, iAvsWrite, iAvsWritedata,
        output oAvsReaddata, oAvsResponse, oAvsWaitrequest,
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output iAvsAddress, iAvsByteenable, iAvsRead, iAvsWrite, iAvsWritedata,
        input  oAvsReaddata, oAvsResponse, oAvsWaitrequest,
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/avalon_axi_lite_master_bridge.sv
// Avalon-MM slave to AXI4-Lite master bridge: one AXI transaction per Avalon access,
// Avalon stalled by waitrequest until the AXI response returns.
module avalon_axi_lite_master_bridge
    import axi_bridge_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR         = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR         = 32'h0000_FFFF,
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32
) (
    input logic                            ACLK,
    input logic                            ARESETN,
    avalon_axi_lite_master_bridge_if.master bus
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    // Offset compare keeps it a single unsigned test even when the base is zero.
    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - C_BASEADDR;
        return (offset <= (C_HIGHADDR - C_BASEADDR));
    endfunction

    state_t                          r_state, w_state_nxt;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
    logic [STRB_W-1:0]               r_strb, w_strb_nxt;
    logic                            r_awvalid, w_awvalid_nxt;
    logic                            r_wvalid, w_wvalid_nxt;
    logic                            r_aw_done, w_aw_done_nxt;
    logic                            r_w_done, w_w_done_nxt;
    logic                            r_bready, w_bready_nxt;
    logic                            r_arvalid, w_arvalid_nxt;
    logic                            r_rready, w_rready_nxt;
    logic [C_M_AXI_DATA_WIDTH-1:0]   r_rdata, w_rdata_nxt;
    logic [1:0]                      r_resp, w_resp_nxt;
    logic                            r_wait, w_wait_nxt;
    logic                            w_aw_fin;
    logic                            w_w_fin;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   w_axi_addr;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_strb_nxt    = r_strb;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_rdata_nxt   = r_rdata;
        w_resp_nxt    = r_resp;
        w_wait_nxt    = r_wait;
        w_aw_fin      = r_aw_done | (r_awvalid & bus.M_AXI_AWREADY);
        w_w_fin       = r_w_done  | (r_wvalid  & bus.M_AXI_WREADY);

        case (r_state)
            ST_IDLE: begin
                w_wait_nxt = 1'b1;
                if (bus.iAvsWrite) begin
                    w_addr_nxt  = bus.iAvsAddress;
                    w_wdata_nxt = bus.iAvsWritedata;
                    w_strb_nxt  = bus.iAvsByteenable;
                    if (addr_in_range(bus.iAvsAddress)) begin
                        w_state_nxt   = ST_WR_XFER;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_aw_done_nxt = 1'b0;
                        w_w_done_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_resp_nxt  = RESP_DECERR;
                        w_wait_nxt  = 1'b0;
                    end
                end else if (bus.iAvsRead) begin
                    w_addr_nxt = bus.iAvsAddress;
                    if (addr_in_range(bus.iAvsAddress)) begin
                        w_state_nxt   = ST_RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_resp_nxt  = RESP_DECERR;
                        w_rdata_nxt = '0;
                        w_wait_nxt  = 1'b0;
                    end
                end
            end
            // AW and W retire independently; each VALID falls right after its own handshake.
            ST_WR_XFER: begin
                w_awvalid_nxt = r_awvalid & ~bus.M_AXI_AWREADY;
                w_wvalid_nxt  = r_wvalid  & ~bus.M_AXI_WREADY;
                w_aw_done_nxt = w_aw_fin;
                w_w_done_nxt  = w_w_fin;
                if (w_aw_fin && w_w_fin) begin
                    w_state_nxt  = ST_WR_RESP;
                    w_bready_nxt = 1'b1;
                end
            end
            ST_WR_RESP: begin
                if (bus.M_AXI_BVALID) begin
                    w_state_nxt  = ST_DONE;
                    w_resp_nxt   = map_axi_resp(bus.M_AXI_BRESP);
                    w_bready_nxt = 1'b0;
                    w_wait_nxt   = 1'b0;
                end
            end
            ST_RD_ADDR: begin
                if (bus.M_AXI_ARREADY) begin
                    w_state_nxt   = ST_RD_DATA;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                end
            end
            ST_RD_DATA: begin
                if (bus.M_AXI_RVALID) begin
                    w_state_nxt  = ST_DONE;
                    w_rdata_nxt  = bus.M_AXI_RDATA;
                    w_resp_nxt   = map_axi_resp(bus.M_AXI_RRESP);
                    w_rready_nxt = 1'b0;
                    w_wait_nxt   = 1'b0;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_wait_nxt  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_wait_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= RESP_OKAY;
            r_wait    <= 1'b1;
        end else begin
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_strb    <= w_strb_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_rdata   <= w_rdata_nxt;
            r_resp    <= w_resp_nxt;
            r_wait    <= w_wait_nxt;
        end
    end

    // AXI-Lite transfers are full words, so the byte offset is dropped.
    assign w_axi_addr = {r_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};

    assign bus.M_AXI_AWADDR    = w_axi_addr;
    assign bus.M_AXI_AWPROT    = 3'b000;
    assign bus.M_AXI_AWVALID   = r_awvalid;
    assign bus.M_AXI_WDATA     = r_wdata;
    assign bus.M_AXI_WSTRB     = r_strb;
    assign bus.M_AXI_WVALID    = r_wvalid;
    assign bus.M_AXI_BREADY    = r_bready;
    assign bus.M_AXI_ARADDR    = w_axi_addr;
    assign bus.M_AXI_ARPROT    = 3'b000;
    assign bus.M_AXI_ARVALID   = r_arvalid;
    assign bus.M_AXI_RREADY    = r_rready;
    assign bus.oAvsReaddata    = r_rdata;
    assign bus.oAvsResponse    = r_resp;
    assign bus.oAvsWaitrequest = r_wait;

endmodule

// File: tb/tb_avalon_axi_lite_master_bridge.sv
// Bench for avalon_axi_lite_master_bridge: Avalon driver, delay-configurable AXI-Lite slave, scoreboard.
module tb_avalon_axi_lite_master_bridge;
    import axi_bridge_pkg::*;

    logic ACLK;
    logic ARESETN;
    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    avalon_axi_lite_master_bridge_if bus ();

    avalon_axi_lite_master_bridge #(
        .C_BASEADDR(32'h0000_0000), .C_HIGHADDR(32'h0000_FFFF),
        .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- AXI-Lite slave model ----------------
    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;
    logic        cfg_hold_r = 1'b0;

    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic        aw_got = 1'b0, w_got = 1'b0, s_bvalid = 1'b0, s_rvalid = 1'b0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;
    logic [31:0] s_rdata = 32'h0;
    int          aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0, b_hs_cnt = 0;
    logic        aw_hs, w_hs, ar_hs;

    assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= cfg_aw_dly);
    assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID  && (w_cnt  >= cfg_w_dly);
    assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (ar_cnt >= cfg_ar_dly);
    assign aw_hs = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
    assign w_hs  = bus.M_AXI_WVALID  && bus.M_AXI_WREADY;
    assign ar_hs = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
    assign bus.M_AXI_BVALID = s_bvalid;
    assign bus.M_AXI_BRESP  = s_bresp;
    assign bus.M_AXI_RVALID = s_rvalid;
    assign bus.M_AXI_RDATA  = s_rdata;
    assign bus.M_AXI_RRESP  = s_rresp;

    always @(posedge ACLK) begin
        if (bus.M_AXI_AWVALID) aw_vcyc <= aw_vcyc + 1;
        if (bus.M_AXI_WVALID)  w_vcyc  <= w_vcyc + 1;
        if (bus.M_AXI_ARVALID) ar_vcyc <= ar_vcyc + 1;
        if (s_bvalid && bus.M_AXI_BREADY) b_hs_cnt <= b_hs_cnt + 1;
        if (!ARESETN) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
        end else begin
            aw_cnt <= aw_hs ? 0 : (bus.M_AXI_AWVALID ? aw_cnt + 1 : aw_cnt);
            w_cnt  <= w_hs  ? 0 : (bus.M_AXI_WVALID  ? w_cnt + 1  : w_cnt);
            ar_cnt <= ar_hs ? 0 : (bus.M_AXI_ARVALID ? ar_cnt + 1 : ar_cnt);
            if (aw_hs) aw_got <= 1'b1;
            if (w_hs)  w_got  <= 1'b1;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                s_bvalid <= 1'b1; s_bresp <= cfg_bresp; aw_got <= 1'b0; w_got <= 1'b0;
            end else if (s_bvalid && bus.M_AXI_BREADY) begin
                s_bvalid <= 1'b0;
            end
            if (ar_hs && !cfg_hold_r) begin
                s_rvalid <= 1'b1; s_rdata <= cfg_rdata; s_rresp <= cfg_rresp;
            end else if (s_rvalid && bus.M_AXI_RREADY) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        chk_rd;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    int          obs_lat;
    logic [1:0]  obs_resp;
    logic [31:0] obs_rdata;
    logic        obs_wait_after;
    logic [2:0]  obs_vld1;
    logic [31:0] obs_awaddr1, obs_wdata1, obs_araddr1;
    logic [3:0]  obs_wstrb1;
    logic [1:0]  obs_rdy2;

    // kind: 0 write, 1 read, 2 read and write together
    task automatic avs_access(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be);
        @(negedge ACLK);
        bus.iAvsAddress    = addr;
        bus.iAvsWritedata  = wdata;
        bus.iAvsByteenable = be;
        bus.iAvsWrite      = (kind != 1);
        bus.iAvsRead       = (kind != 0);
        obs_lat = -1;
        obs_vld1 = 3'bxxx;
        obs_rdy2 = 2'bxx;
        for (int c = 1; c <= 100; c++) begin
            @(negedge ACLK);
            if (c == 1) begin
                obs_vld1    = {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID};
                obs_awaddr1 = bus.M_AXI_AWADDR;
                obs_wdata1  = bus.M_AXI_WDATA;
                obs_wstrb1  = bus.M_AXI_WSTRB;
                obs_araddr1 = bus.M_AXI_ARADDR;
            end
            if (c == 2) obs_rdy2 = {bus.M_AXI_BREADY, bus.M_AXI_RREADY};
            if (!bus.oAvsWaitrequest) begin
                obs_lat   = c;
                obs_resp  = bus.oAvsResponse;
                obs_rdata = bus.oAvsReaddata;
                break;
            end
        end
        bus.iAvsWrite = 1'b0;
        bus.iAvsRead  = 1'b0;
        @(negedge ACLK);
        obs_wait_after = bus.oAvsWaitrequest;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        bus.iAvsAddress = '0; bus.iAvsWritedata = '0; bus.iAvsByteenable = '0;
        bus.iAvsWrite = 1'b0; bus.iAvsRead = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        checks++; if (bus.oAvsWaitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait got %b exp 1", bus.oAvsWaitrequest); end
        checks++; if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID} !== 3'b000) begin errors++; $display("FAIL rst_valids got %b exp 000", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID}); end
        checks++; if ({bus.M_AXI_BREADY, bus.M_AXI_RREADY} !== 2'b00) begin errors++; $display("FAIL rst_readys got %b exp 00", {bus.M_AXI_BREADY, bus.M_AXI_RREADY}); end
        checks++; if (bus.oAvsResponse !== 2'b00) begin errors++; $display("FAIL rst_resp got %b exp 00", bus.oAvsResponse); end
        checks++; if (bus.oAvsReaddata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.oAvsReaddata); end
        checks++; if (bus.M_AXI_AWADDR !== 32'h0) begin errors++; $display("FAIL rst_awaddr got %h exp 0", bus.M_AXI_AWADDR); end
        ARESETN = 1'b1;
    endtask

    task automatic test_write_basic();
        exp_t e, g;
        int b0;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_bresp = 2'b00;
        b0 = b_hs_cnt;
        e.resp = RESP_OKAY; e.rdata = 32'h0; e.chk_rd = 1'b0; e.lat = 3;
        exp_q.push_back(e);
        avs_access(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        g = exp_q.pop_front();
        checks++; if (obs_lat !== g.lat) begin errors++; $display("FAIL wr_lat got %0d exp %0d", obs_lat, g.lat); end
        checks++; if (obs_resp !== g.resp) begin errors++; $display("FAIL wr_resp got %b exp %b", obs_resp, g.resp); end
        checks++; if (obs_vld1 !== 3'b110) begin errors++; $display("FAIL wr_vld_n1 got %b exp 110", obs_vld1); end
        checks++; if (obs_awaddr1 !== 32'h10) begin errors++; $display("FAIL wr_awaddr got %h exp 10", obs_awaddr1); end
        checks++; if (obs_wdata1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_wdata got %h exp deadbeef", obs_wdata1); end
        checks++; if (obs_wstrb1 !== 4'hF) begin errors++; $display("FAIL wr_wstrb got %h exp f", obs_wstrb1); end
        checks++; if (obs_rdy2 !== 2'b10) begin errors++; $display("FAIL wr_bready_n2 got %b exp 10", obs_rdy2); end
        checks++; if (obs_wait_after !== 1'b1) begin errors++; $display("FAIL wr_one_cycle got %b exp 1", obs_wait_after); end
        checks++; if (b_hs_cnt - b0 !== 1) begin errors++; $display("FAIL wr_b_count got %0d exp 1", b_hs_cnt - b0); end
        // unaligned byte address must reach AXI word-aligned
        e.lat = 3;
        exp_q.push_back(e);
        avs_access(0, 32'h0000_0107, 32'h0000_A5A5, 4'h3);
        g = exp_q.pop_front();
        checks++; if (obs_lat !== g.lat) begin errors++; $display("FAIL wr2_lat got %0d exp %0d", obs_lat, g.lat); end
        checks++; if (obs_awaddr1 !== 32'h104) begin errors++; $display("FAIL wr2_awaddr got %h exp 104", obs_awaddr1); end
        checks++; if (obs_wstrb1 !== 4'h3) begin errors++; $display("FAIL wr2_wstrb got %h exp 3", obs_wstrb1); end
    endtask

    task automatic test_read_delayed();
        exp_t e, g;
        int a0;
        cfg_ar_dly = 3; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
        a0 = ar_vcyc;
        e.resp = RESP_OKAY; e.rdata = 32'h1234_5678; e.chk_rd = 1'b1; e.lat = 3 + 3;
        exp_q.push_back(e);
        avs_access(1, 32'h0000_0020, 32'h0, 4'h0);
        g = exp_q.pop_front();
        checks++; if (obs_lat !== g.lat) begin errors++; $display("FAIL rd_lat got %0d exp %0d", obs_lat, g.lat); end
        checks++; if (obs_rdata !== g.rdata) begin errors++; $display("FAIL rd_data got %h exp %h", obs_rdata, g.rdata); end
        checks++; if (obs_resp !== g.resp) begin errors++; $display("FAIL rd_resp got %b exp %b", obs_resp, g.resp); end
        checks++; if (ar_vcyc - a0 !== 4) begin errors++; $display("FAIL rd_arvalid_cycles got %0d exp 4", ar_vcyc - a0); end
        checks++; if (obs_vld1 !== 3'b001) begin errors++; $display("FAIL rd_vld_n1 got %b exp 001", obs_vld1); end
        checks++; if (obs_araddr1 !== 32'h20) begin errors++; $display("FAIL rd_araddr got %h exp 20", obs_araddr1); end
        checks++; if (obs_wait_after !== 1'b1) begin errors++; $display("FAIL rd_one_cycle got %b exp 1", obs_wait_after); end
        cfg_ar_dly = 0;
    endtask

    task automatic test_write_skew();
        int aw_d[3] = '{3, 2, 0};
        int w_d[3]  = '{1, 2, 2};
        exp_t e, g;
        int a0, w0, r0, b0;
        cfg_bresp = 2'b00;
        for (int i = 0; i < 3; i++) begin
            cfg_aw_dly = aw_d[i]; cfg_w_dly = w_d[i];
            a0 = aw_vcyc; w0 = w_vcyc; r0 = ar_vcyc; b0 = b_hs_cnt;
            e.resp = RESP_OKAY; e.rdata = 32'h0; e.chk_rd = 1'b0;
            e.lat = 3 + ((aw_d[i] > w_d[i]) ? aw_d[i] : w_d[i]);
            exp_q.push_back(e);
            avs_access(0, 32'h0000_0040 + 32'(i * 4), 32'h0BAD_0000 + 32'(i), 4'hF);
            g = exp_q.pop_front();
            checks++; if (obs_lat !== g.lat) begin errors++; $display("FAIL skew%0d_lat got %0d exp %0d", i, obs_lat, g.lat); end
            checks++; if (aw_vcyc - a0 !== aw_d[i] + 1) begin errors++; $display("FAIL skew%0d_awvalid_cycles got %0d exp %0d", i, aw_vcyc - a0, aw_d[i] + 1); end
            checks++; if (w_vcyc - w0 !== w_d[i] + 1) begin errors++; $display("FAIL skew%0d_wvalid_cycles got %0d exp %0d", i, w_vcyc - w0, w_d[i] + 1); end
            checks++; if (b_hs_cnt - b0 !== 1) begin errors++; $display("FAIL skew%0d_b_count got %0d exp 1", i, b_hs_cnt - b0); end
            checks++; if (ar_vcyc - r0 !== 0) begin errors++; $display("FAIL skew%0d_no_ar got %0d exp 0", i, ar_vcyc - r0); end
            checks++; if (obs_wait_after !== 1'b1) begin errors++; $display("FAIL skew%0d_one_cycle got %b exp 1", i, obs_wait_after); end
        end
        cfg_aw_dly = 0; cfg_w_dly = 0;
    endtask

    task automatic test_rw_collision();
        int a0, r0;
        a0 = aw_vcyc; r0 = ar_vcyc;
        avs_access(2, 32'h0000_0080, 32'h5555_AAAA, 4'hF);
        checks++; if (obs_lat !== 3) begin errors++; $display("FAIL rw_lat got %0d exp 3", obs_lat); end
        checks++; if (aw_vcyc - a0 !== 1) begin errors++; $display("FAIL rw_write_wins got %0d exp 1", aw_vcyc - a0); end
        checks++; if (ar_vcyc - r0 !== 0) begin errors++; $display("FAIL rw_read_ignored got %0d exp 0", ar_vcyc - r0); end
    endtask

    task automatic test_out_of_range();
        int a0, w0, r0;
        cfg_rdata = 32'h7777_1111; cfg_rresp = 2'b00;
        avs_access(1, 32'h0000_FFFC, 32'h0, 4'h0);
        checks++; if (obs_lat !== 3) begin errors++; $display("FAIL oor_edge_lat got %0d exp 3", obs_lat); end
        checks++; if (obs_rdata !== 32'h7777_1111) begin errors++; $display("FAIL oor_edge_data got %h exp 77771111", obs_rdata); end
        a0 = aw_vcyc; w0 = w_vcyc; r0 = ar_vcyc;
        avs_access(0, 32'h0001_0000, 32'hFFFF_FFFF, 4'hF);
        checks++; if (obs_lat !== 1) begin errors++; $display("FAIL oor_wr_lat got %0d exp 1", obs_lat); end
        checks++; if (obs_resp !== RESP_DECERR) begin errors++; $display("FAIL oor_wr_resp got %b exp 11", obs_resp); end
        checks++; if (obs_wait_after !== 1'b1) begin errors++; $display("FAIL oor_wr_one_cycle got %b exp 1", obs_wait_after); end
        avs_access(1, 32'h0002_0004, 32'h0, 4'h0);
        checks++; if (obs_lat !== 1) begin errors++; $display("FAIL oor_rd_lat got %0d exp 1", obs_lat); end
        checks++; if (obs_resp !== RESP_DECERR) begin errors++; $display("FAIL oor_rd_resp got %b exp 11", obs_resp); end
        checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL oor_rd_data got %h exp 0", obs_rdata); end
        checks++; if ((aw_vcyc - a0) + (w_vcyc - w0) + (ar_vcyc - r0) !== 0) begin errors++; $display("FAIL oor_no_axi got %0d exp 0", (aw_vcyc - a0) + (w_vcyc - w0) + (ar_vcyc - r0)); end
    endtask

    task automatic test_resp_map();
        cfg_bresp = RESP_SLVERR;
        avs_access(0, 32'h0000_0200, 32'h1, 4'hF);
        checks++; if (obs_resp !== 2'b10) begin errors++; $display("FAIL map_bresp10 got %b exp 10", obs_resp); end
        cfg_rresp = RESP_EXOKAY; cfg_rdata = 32'h0000_00E1;
        avs_access(1, 32'h0000_0204, 32'h0, 4'h0);
        checks++; if (obs_resp !== 2'b00) begin errors++; $display("FAIL map_rresp01 got %b exp 00", obs_resp); end
        cfg_rresp = RESP_DECERR;
        avs_access(1, 32'h0000_0208, 32'h0, 4'h0);
        checks++; if (obs_resp !== 2'b11) begin errors++; $display("FAIL map_rresp11 got %b exp 11", obs_resp); end
        cfg_bresp = RESP_OKAY; cfg_rresp = RESP_OKAY;
    endtask

    task automatic test_reset_mid();
        logic seen;
        seen = 1'b0;
        cfg_hold_r = 1'b1;
        @(negedge ACLK);
        bus.iAvsAddress = 32'h0000_0030; bus.iAvsRead = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            if (bus.M_AXI_RREADY) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rmid_reach_rd_data got %b exp 1", seen); end
        ARESETN = 1'b0; bus.iAvsRead = 1'b0;
        @(negedge ACLK);
        checks++; if (bus.M_AXI_ARVALID !== 1'b0) begin errors++; $display("FAIL rmid_arvalid got %b exp 0", bus.M_AXI_ARVALID); end
        checks++; if (bus.M_AXI_RREADY !== 1'b0) begin errors++; $display("FAIL rmid_rready got %b exp 0", bus.M_AXI_RREADY); end
        checks++; if (bus.oAvsWaitrequest !== 1'b1) begin errors++; $display("FAIL rmid_wait got %b exp 1", bus.oAvsWaitrequest); end
        checks++; if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL rmid_state got %0d exp 0", dut.r_state); end
        ARESETN = 1'b1; cfg_hold_r = 1'b0; cfg_rdata = 32'hCAFE_F00D;
        avs_access(1, 32'h0000_0030, 32'h0, 4'h0);
        checks++; if (obs_lat !== 3) begin errors++; $display("FAIL rmid_after_lat got %0d exp 3", obs_lat); end
        checks++; if (obs_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rmid_after_data got %h exp cafef00d", obs_rdata); end
    endtask

    task automatic test_back_to_back();
        exp_t e, g;
        int k;
        logic [31:0] addr;
        for (int i = 0; i < 8; i++) begin
            k = int'($urandom_range(0, 1));
            cfg_aw_dly = int'($urandom_range(0, 2));
            cfg_w_dly  = int'($urandom_range(0, 2));
            cfg_ar_dly = int'($urandom_range(0, 2));
            cfg_rdata  = $urandom;
            addr = $urandom & 32'h0000_FFFC;
            e.resp = RESP_OKAY;
            e.chk_rd = (k == 1);
            e.rdata = cfg_rdata;
            e.lat = (k == 1) ? 3 + cfg_ar_dly : 3 + ((cfg_aw_dly > cfg_w_dly) ? cfg_aw_dly : cfg_w_dly);
            exp_q.push_back(e);
            avs_access(k, addr, $urandom, 4'hF);
            g = exp_q.pop_front();
            checks++; if (obs_lat !== g.lat) begin errors++; $display("FAIL b2b%0d_lat got %0d exp %0d", i, obs_lat, g.lat); end
            checks++; if (obs_resp !== g.resp) begin errors++; $display("FAIL b2b%0d_resp got %b exp %b", i, obs_resp, g.resp); end
            if (g.chk_rd) begin
                checks++; if (obs_rdata !== g.rdata) begin errors++; $display("FAIL b2b%0d_rdata got %h exp %h", i, obs_rdata, g.rdata); end
            end
        end
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_ar_dly = 0;
    endtask

    initial begin
        ARESETN = 1'b0;
        test_reset();
        test_write_basic();
        test_read_delayed();
        test_write_skew();
        test_rw_collision();
        test_out_of_range();
        test_resp_map();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
